id_exe_pipe_reg: RTL and testbench

- ID/EX pipeline register that directly consumes the hazard detector's `hazard` output.
- Latches decoded ID-stage fields on each clock edge. Inserts a bubble on hazard or branch flush, and holds its contents on a global freeze (memory stall).
- Feeds back `exe_dst`, `exe_wb_en` and `exe_mem_r_en` to the hazard detector, and `exe_src1`/`exe_src2` to the forwarding unit.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_act_sel.sv | 24 ++
 rtl/id_exe_pipe_reg.sv | 129 ++++++++++++
 tb/tb_id_exe_pipe_reg.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: field widths, the ID/EX bundle, its bubble value and the
// per-edge action decoded from freeze/flush/hazard.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CMD_W  = 4;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] stVal;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  dst;
        logic [CMD_W-1:0]  exeCmd;
        logic              memREn;
        logic              memWEn;
        logic              wbEn;
        logic              isImm;
        logic              brType;
        logic              valid;
    } id_exe_t;

    // Register indices of 0 never match in hazard/forwarding, so an all-zero
    // bundle is a harmless NOP that cannot cause a false stall.
    localparam id_exe_t ID_EXE_BUBBLE = '0;

    typedef enum logic [1:0] {
        HOLD,
        FLUSH,
        BUBBLE,
        LOAD
    } pipe_act_e;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_act_sel.sv
// Priority decode of the pipeline controls into one action per edge.
// Also used by the IF/ID register, which treats BUBBLE as HOLD.
module pipe_act_sel
    import pipe_pkg::*;
(
    input  logic      freeze_i,
    input  logic      flush_i,
    input  logic      hazard_i,
    output pipe_act_e act_o
);

    // Freeze beats flush, flush beats hazard.
    always_comb begin
        act_o = LOAD;
        if (freeze_i) begin
            act_o = HOLD;
        end else if (flush_i) begin
            act_o = FLUSH;
        end else if (hazard_i) begin
            act_o = BUBBLE;
        end
    end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EX pipeline register with bubble insertion and freeze hold.
// Optional STALL_STATS_EN adds saturating bubble/flush counters.
module id_exe_pipe_reg
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [REG_W-1:0]  id_dst,
    input  logic [CMD_W-1:0]  id_exe_cmd,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_wb_en,
    input  logic              id_is_imm,
    input  logic              id_br_type,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_st_val,
    output logic [DATA_W-1:0] exe_imm,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [REG_W-1:0]  exe_dst,
    output logic [CMD_W-1:0]  exe_exe_cmd,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_wb_en,
    output logic              exe_is_imm,
    output logic              exe_br_type,
`ifdef STALL_STATS_EN
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              exe_valid
);

    pipe_act_e act;
    id_exe_t   loadVal;
    id_exe_t   stage_d;
    id_exe_t   stage_q;

    pipe_act_sel uActSel (
        .freeze_i (freeze),
        .flush_i  (flush),
        .hazard_i (hazard),
        .act_o    (act)
    );

    always_comb begin
        loadVal        = ID_EXE_BUBBLE;
        loadVal.pc     = id_pc;
        loadVal.val1   = id_val1;
        loadVal.val2   = id_val2;
        loadVal.stVal  = id_st_val;
        loadVal.imm    = id_imm;
        loadVal.src1   = id_src1;
        loadVal.src2   = id_src2;
        loadVal.dst    = id_dst;
        loadVal.exeCmd = id_exe_cmd;
        loadVal.memREn = id_mem_r_en;
        loadVal.memWEn = id_mem_w_en;
        loadVal.wbEn   = id_wb_en;
        loadVal.isImm  = id_is_imm;
        loadVal.brType = id_br_type;
        loadVal.valid  = 1'b1;
    end

    always_comb begin
        stage_d = stage_q;
        unique case (act)
            HOLD:          stage_d = stage_q;
            FLUSH, BUBBLE: stage_d = ID_EXE_BUBBLE;
            LOAD:          stage_d = loadVal;
            default:       stage_d = stage_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= ID_EXE_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] bubbleCnt_q;
    logic [CNT_W-1:0] flushCnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubbleCnt_q <= '0;
            flushCnt_q  <= '0;
        end else begin
            if (act == BUBBLE) bubbleCnt_q <= satInc(bubbleCnt_q);
            if (act == FLUSH)  flushCnt_q  <= satInc(flushCnt_q);
        end
    end

    assign bubble_cnt = bubbleCnt_q;
    assign flush_cnt  = flushCnt_q;
`endif

    assign exe_pc       = stage_q.pc;
    assign exe_val1     = stage_q.val1;
    assign exe_val2     = stage_q.val2;
    assign exe_st_val   = stage_q.stVal;
    assign exe_imm      = stage_q.imm;
    assign exe_src1     = stage_q.src1;
    assign exe_src2     = stage_q.src2;
    assign exe_dst      = stage_q.dst;
    assign exe_exe_cmd  = stage_q.exeCmd;
    assign exe_mem_r_en = stage_q.memREn;
    assign exe_mem_w_en = stage_q.memWEn;
    assign exe_wb_en    = stage_q.wbEn;
    assign exe_is_imm   = stage_q.isImm;
    assign exe_br_type  = stage_q.brType;
    assign exe_valid    = stage_q.valid;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: directed table, random run against a
// reference model, async reset; counter checks when STALL_STATS_EN is defined.
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] stVal;
        logic [31:0] imm;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic [3:0]  cmd;
        logic        memR;
        logic        memW;
        logic        wb;
        logic        isImm;
        logic        br;
        logic        valid;
    } tbFields_t;

    typedef struct packed {
        logic        fr;
        logic        fl;
        logic        hz;
        logic [4:0]  idDst;
        logic        idWb;
        logic        idMemW;
        logic [31:0] idVal1;
        logic        expValid;
        logic [4:0]  expDst;
        logic        expWb;
        logic        expMemW;
        logic [31:0] expVal1;
        logic [15:0] expBub;
        logic [15:0] expFl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0, flush = 1'b0, hazard = 1'b0;
    logic [31:0] id_pc = '0, id_val1 = '0, id_val2 = '0, id_st_val = '0, id_imm = '0;
    logic [4:0]  id_src1 = '0, id_src2 = '0, id_dst = '0;
    logic [3:0]  id_exe_cmd = '0;
    logic        id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, id_wb_en = 1'b0;
    logic        id_is_imm = 1'b0, id_br_type = 1'b0;
    logic [31:0] exe_pc, exe_val1, exe_val2, exe_st_val, exe_imm;
    logic [4:0]  exe_src1, exe_src2, exe_dst;
    logic [3:0]  exe_exe_cmd;
    logic        exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_is_imm, exe_br_type;
    logic        exe_valid;
`ifdef STALL_STATS_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    tbFields_t   model;
    int unsigned modelBub;
    int unsigned modelFl;

    id_exe_pipe_reg dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .hazard       (hazard),
        .id_pc        (id_pc),
        .id_val1      (id_val1),
        .id_val2      (id_val2),
        .id_st_val    (id_st_val),
        .id_imm       (id_imm),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_dst       (id_dst),
        .id_exe_cmd   (id_exe_cmd),
        .id_mem_r_en  (id_mem_r_en),
        .id_mem_w_en  (id_mem_w_en),
        .id_wb_en     (id_wb_en),
        .id_is_imm    (id_is_imm),
        .id_br_type   (id_br_type),
        .exe_pc       (exe_pc),
        .exe_val1     (exe_val1),
        .exe_val2     (exe_val2),
        .exe_st_val   (exe_st_val),
        .exe_imm      (exe_imm),
        .exe_src1     (exe_src1),
        .exe_src2     (exe_src2),
        .exe_dst      (exe_dst),
        .exe_exe_cmd  (exe_exe_cmd),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_mem_w_en (exe_mem_w_en),
        .exe_wb_en    (exe_wb_en),
        .exe_is_imm   (exe_is_imm),
        .exe_br_type  (exe_br_type),
`ifdef STALL_STATS_EN
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .exe_valid    (exe_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic tbFields_t randomId();
        tbFields_t f;
        f.pc    = $urandom;
        f.val1  = $urandom;
        f.val2  = $urandom;
        f.stVal = $urandom;
        f.imm   = $urandom;
        f.src1  = 5'($urandom_range(31));
        f.src2  = 5'($urandom_range(31));
        f.dst   = 5'($urandom_range(31));
        f.cmd   = 4'($urandom_range(15));
        f.memR  = 1'($urandom_range(1));
        f.memW  = 1'($urandom_range(1));
        f.wb    = 1'($urandom_range(1));
        f.isImm = 1'($urandom_range(1));
        f.br    = 1'($urandom_range(1));
        f.valid = 1'b0;
        return f;
    endfunction

    function automatic tbFields_t sampleDut();
        tbFields_t a;
        a = '{exe_pc, exe_val1, exe_val2, exe_st_val, exe_imm, exe_src1, exe_src2,
              exe_dst, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en,
              exe_is_imm, exe_br_type, exe_valid};
        return a;
    endfunction

    // Reference behaviour: freeze keeps everything, flush or hazard yields an
    // all-zero NOP, anything else copies the ID fields as a valid instruction.
    task automatic modelStep(input logic fr, input logic fl, input logic hz,
                             input tbFields_t idF);
        if (!fr) begin
            if (fl || hz) begin
                model = '0;
                if (fl) modelFl  = (modelFl  < 65535) ? modelFl  + 1 : 65535;
                else    modelBub = (modelBub < 65535) ? modelBub + 1 : 65535;
            end else begin
                model       = idF;
                model.valid = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic fl, input logic hz,
                                 input tbFields_t idF);
        freeze      = fr;
        flush       = fl;
        hazard      = hz;
        id_pc       = idF.pc;
        id_val1     = idF.val1;
        id_val2     = idF.val2;
        id_st_val   = idF.stVal;
        id_imm      = idF.imm;
        id_src1     = idF.src1;
        id_src2     = idF.src2;
        id_dst      = idF.dst;
        id_exe_cmd  = idF.cmd;
        id_mem_r_en = idF.memR;
        id_mem_w_en = idF.memW;
        id_wb_en    = idF.wb;
        id_is_imm   = idF.isImm;
        id_br_type  = idF.br;
        modelStep(fr, fl, hz, idF);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input tbFields_t exp);
        tbFields_t act;
        act = sampleDut();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCounters(input string name);
`ifdef STALL_STATS_EN
        checkValue({name, "_bubble_cnt"}, 64'(bubble_cnt), 64'(modelBub));
        checkValue({name, "_flush_cnt"},  64'(flush_cnt),  64'(modelFl));
`else
        if (name.len() < 0) $display("[TB] %s", name);
`endif
    endtask

    vec_t vecs[10];

    initial begin
        tbFields_t idF;
        int        fr, fl, hz;

        // Directed sequence: load, two hazard bubbles, re-load, freeze priority,
        // flush, flush over hazard, frozen bubble, load.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h1234, 1'b1, 5'd5, 1'b1, 1'b0, 32'h1234, 16'd0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 32'hAAAA, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,    16'd1, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 32'hAAAA, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,    16'd2, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 32'hAAAA, 1'b1, 5'd9, 1'b1, 1'b1, 32'hAAAA, 16'd2, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 32'h77,   1'b1, 5'd7, 1'b0, 1'b0, 32'h77,   16'd2, 16'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 32'h33,   1'b1, 5'd7, 1'b0, 1'b0, 32'h77,   16'd2, 16'd0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 32'h33,   1'b0, 5'd0, 1'b0, 1'b0, 32'h0,    16'd2, 16'd1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 32'h33,   1'b0, 5'd0, 1'b0, 1'b0, 32'h0,    16'd2, 16'd2};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h44,   1'b0, 5'd0, 1'b0, 1'b0, 32'h0,    16'd2, 16'd2};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h44,   1'b1, 5'd4, 1'b1, 1'b0, 32'h44,   16'd2, 16'd2};

        model    = '0;
        modelBub = 0;
        modelFl  = 0;

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", '0);
        checkCounters("reset");
        rst = 1'b1;

        foreach (vecs[i]) begin
            idF        = randomId();
            idF.dst    = vecs[i].idDst;
            idF.wb     = vecs[i].idWb;
            idF.memW   = vecs[i].idMemW;
            idF.val1   = vecs[i].idVal1;
            applyStimulus(vecs[i].fr, vecs[i].fl, vecs[i].hz, idF);
            checkValue($sformatf("vec%0d", i),
                       64'({exe_valid, exe_dst, exe_wb_en, exe_mem_w_en, exe_val1}),
                       64'({vecs[i].expValid, vecs[i].expDst, vecs[i].expWb,
                            vecs[i].expMemW, vecs[i].expVal1}));
`ifdef STALL_STATS_EN
            checkValue($sformatf("vec%0d_bubble_cnt", i), 64'(bubble_cnt), 64'(vecs[i].expBub));
            checkValue($sformatf("vec%0d_flush_cnt", i),  64'(flush_cnt),  64'(vecs[i].expFl));
`endif
        end

        for (int n = 0; n < 300; n++) begin
            fr = ($urandom_range(3) == 0) ? 1 : 0;
            fl = ($urandom_range(5) == 0) ? 1 : 0;
            hz = ($urandom_range(2) == 0) ? 1 : 0;
            applyStimulus(1'(fr), 1'(fl), 1'(hz), randomId());
            checkOutput($sformatf("random%0d", n), model);
        end
        checkCounters("random_end");

        // Asynchronous reset between edges while a real instruction is held.
        idF = randomId();
        applyStimulus(1'b0, 1'b0, 1'b0, idF);
        checkOutput("pre_async_load", model);
        #2 rst = 1'b0;
        #1;
        model    = '0;
        modelBub = 0;
        modelFl  = 0;
        checkOutput("async_reset", '0);
        checkCounters("async_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        idF = randomId();
        applyStimulus(1'b0, 1'b0, 1'b0, idF);
        checkOutput("load_after_reset", model);

`ifdef STALL_STATS_EN
        freeze = 1'b0;
        flush  = 1'b0;
        hazard = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        checkValue("saturate_bubble_cnt", 64'(bubble_cnt), 64'h0000_0000_0000_FFFF);
        checkValue("saturate_flush_cnt",  64'(flush_cnt),  64'h0);
        checkOutput("saturate_bubble_state", '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
